// File: rtl/io_config_loader.sv
// Serial configuration loader for one IO block: hunts for a sync byte, shifts a frame
// into a shadow register, and commits it to the live switch vector only on a good checksum.
module io_config_loader #(
  parameter int          WS     = 6,
  parameter int          WD     = 3,
  parameter int          WG     = 3,
  parameter int          EXTIN  = 3,
  parameter int          EXTOUT = 3,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cfg_valid,
  input  logic                                      cfg_data,
  output logic                                      cfg_ready,
  output logic [(EXTIN+EXTOUT)*(WS+WD+WG)-1:0]      c,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int CW    = (EXTIN + EXTOUT) * (WS + WD + WG);
  localparam int CWP   = ((CW + 7) / 8) * 8;
  localparam int CNT_W = $clog2(CWP + 1);

  typedef enum logic [1:0] {HUNT, LOAD, CHK, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [CW-1:0]    shadow_q, shadow_d;
  logic [CW-1:0]    c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ccnt_q, ccnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       chk_q, chk_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             take;

  assign take = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    ccnt_d   = ccnt_q;
    acc_d    = acc_q;
    chk_d    = chk_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      HUNT: begin
        if (take) begin
          win_d = {cfg_data, win_q[7:1]};
          if (win_d == SYNC) begin
            state_d = LOAD;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
      end
      LOAD: begin
        if (take) begin
          // Pad bits beyond CW fall through the loop unstored but still feed the checksum.
          for (int i = 0; i < CW; i++) begin
            if (cnt_q == CNT_W'(i)) shadow_d[i] = cfg_data;
          end
          acc_d[cnt_q[2:0]] = acc_q[cnt_q[2:0]] ^ cfg_data;
          if (cnt_q == CNT_W'(CWP - 1)) begin
            state_d = CHK;
            ccnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHK: begin
        if (take) begin
          chk_d[ccnt_q] = cfg_data;
          if (ccnt_q == 3'd7) state_d = COMMIT;
          else                ccnt_d  = ccnt_q + 1'b1;
        end
      end
      COMMIT: begin
        if (chk_q == acc_q) begin
          c_d    = shadow_q;
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        state_d = HUNT;
        win_d   = '0;
        cnt_d   = '0;
        ccnt_d  = '0;
      end
      default: state_d = HUNT;
    endcase
    // Handshake and status outputs are registered from the next state.
    cfg_ready_d = (state_d != COMMIT);
    busy_d      = (state_d == LOAD) || (state_d == CHK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      win_q       <= '0;
      shadow_q    <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      ccnt_q      <= '0;
      acc_q       <= '0;
      chk_q       <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      shadow_q    <= shadow_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      ccnt_q      <= ccnt_d;
      acc_q       <= acc_d;
      chk_q       <= chk_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign c         = c_q;

endmodule

// File: tb/tb_io_config_loader.sv
// Directed-plus-random bench for io_config_loader with a frame-level reference model.
module tb_io_config_loader;

  localparam int CW  = 72;
  localparam int CWP = 72;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_data = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] c;
  logic          busy;
  logic          done;
  logic          err;

  io_config_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .c(c), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int stalls = 0;
  logic [CW-1:0] exp_c;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checksum of a frame: XOR of all payload bytes (zero pad up to CWP).
  function automatic logic [7:0] ref_chk(input logic [CW-1:0] p);
    logic [CWP-1:0] padded;
    logic [7:0] r;
    padded = CWP'(p);
    r = 8'h00;
    for (int b = 0; b < CWP / 8; b++) r ^= padded[8*b +: 8];
    return r;
  endfunction

  // Index of the first position where the sync byte (LSB first) ends in a bit stream.
  function automatic int first_sync_end(input bit q[$]);
    logic [7:0] s;
    bit hit;
    s = 8'hA5;
    for (int i = 0; i + 8 <= q.size(); i++) begin
      hit = 1'b1;
      for (int j = 0; j < 8; j++) if (q[i+j] != s[j]) hit = 1'b0;
      if (hit) return i + 7;
    end
    return -1;
  endfunction

  task automatic send_bit(input logic b, input int gmax);
    int g;
    int n;
    logic r;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    if (g > 0) begin
      cfg_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    n = 0;
    forever begin
      r = cfg_ready;
      @(posedge clk); #1;
      if (r) break;
      stalls++;
      n++;
      if (n > 20) begin
        chk1("bit_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic send_sync(input int gmax);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(s[i], gmax);
  endtask

  task automatic send_payload(input logic [CW-1:0] p, input int n, input int gmax);
    logic [CWP-1:0] padded;
    padded = CWP'(p);
    for (int k = 0; k < n; k++) send_bit(padded[k], gmax);
  endtask

  task automatic send_chk(input logic [7:0] ck, input int gmax);
    for (int i = 0; i < 8; i++) send_bit(ck[i], gmax);
  endtask

  // Called right after the last checksum bit was accepted.
  task automatic finish_check(input string tag, input logic [CW-1:0] p, input logic [7:0] ck);
    logic commit;
    int d0;
    int e0;
    commit = (ck == ref_chk(p));
    d0 = done_cnt;
    e0 = err_cnt;
    cfg_valid = 1'b0;
    chk1({tag, "_commit_rdy"}, cfg_ready, 1'b0);
    chk1({tag, "_commit_busy"}, busy, 1'b0);
    chkc({tag, "_c_hold"}, c, exp_c);
    @(posedge clk); #1;
    if (commit) exp_c = p;
    chk1({tag, "_done"}, done, commit);
    chk1({tag, "_err"}, err, !commit);
    chkc({tag, "_c"}, c, exp_c);
    @(posedge clk); #1;
    chk1({tag, "_done_end"}, done, 1'b0);
    chk1({tag, "_err_end"}, err, 1'b0);
    chki({tag, "_done_cnt"}, done_cnt, d0 + (commit ? 1 : 0));
    chki({tag, "_err_cnt"}, err_cnt, e0 + (commit ? 0 : 1));
  endtask

  task automatic run_frame(input string tag, input logic [CW-1:0] p, input logic [7:0] ck,
                           input int gmax);
    send_sync(gmax);
    chk1({tag, "_busy_load"}, busy, 1'b1);
    send_payload(p, CWP, gmax);
    send_chk(ck, gmax);
    finish_check(tag, p, ck);
  endtask

  initial begin
    logic [CW-1:0] p;
    logic [CW-1:0] pa;
    logic [CW-1:0] pb;
    logic [7:0] ck;
    bit q[$];
    bit garb[5];
    int d0;

    exp_c = '0;
    #12;
    chkc("rst_c", c, '0);
    chk1("rst_ready", cfg_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("hunt_ready", cfg_ready, 1'b1);
    chk1("hunt_busy", busy, 1'b0);

    run_frame("one", 72'h1, 8'h01, 0);
    chkc("one_c_const", c, 72'h1);

    run_frame("ones_bad", '1, 8'h01, 0);
    chkc("ones_bad_c_const", c, 72'h1);
    run_frame("ones_good", '1, 8'hFF, 0);
    chkc("ones_good_c_const", c, '1);

    // Garbage prefix chosen so that no sync appears before the real one.
    forever begin
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(1'b0);
      for (int i = 0; i < 5; i++) begin
        garb[i] = bit'($urandom_range(1, 0));
        q.push_back(garb[i]);
      end
      begin
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < 8; i++) q.push_back(s[i]);
      end
      if (first_sync_end(q) == q.size() - 1) break;
    end
    for (int i = 0; i < 5; i++) send_bit(garb[i], 0);
    run_frame("garbage", '0, 8'h00, 0);
    chkc("garbage_c_const", c, '0);

    for (int t = 0; t < 3; t++) begin
      p = {8'($urandom), $urandom, $urandom};
      run_frame("gaps", p, ref_chk(p), 7);
    end
    p = {8'($urandom), $urandom, $urandom};
    ck = ref_chk(p) ^ 8'($urandom_range(255, 1));
    run_frame("rand_bad", p, ck, 3);

    run_frame("pre_rst", 72'h1, 8'h01, 0);
    p = {8'($urandom), $urandom, $urandom};
    send_sync(0);
    send_payload(p, 40, 0);
    cfg_valid = 1'b0;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chkc("midrst_c", c, '0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", cfg_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_c = '0;
    repeat (3) begin @(posedge clk); #1; end
    chki("midrst_no_done", done_cnt, d0);
    chkc("midrst_c_hold", c, '0);
    p = {8'($urandom), $urandom, $urandom};
    run_frame("post_rst", p, ref_chk(p), 2);

    pa = {8'($urandom), $urandom, $urandom};
    pb = {8'($urandom), $urandom, $urandom};
    stalls = 0;
    d0 = done_cnt;
    send_sync(0);
    send_payload(pa, CWP, 0);
    send_chk(ref_chk(pa), 0);
    send_sync(0);
    send_payload(pb, CWP, 0);
    send_chk(ref_chk(pb), 0);
    exp_c = pa;
    finish_check("b2b", pb, ref_chk(pb));
    chki("b2b_stalls", stalls, 1);
    chki("b2b_done_cnt", done_cnt, d0 + 2);
    chkc("b2b_c_final", c, pb);

    chki("done_err_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_config_loader.md
Name: io_config_loader

Overview:
- Writer side of the IO block configuration vector. Receives a framed serial configuration bitstream, checks it, and drives the c[(EXTIN+EXTOUT)*(WS+WD+WG)-1:0] bits that select transmission gates between single/double/global tracks and external pins.
- One loader sits per IO block on the configuration chain.
- A shadow register accepts the frame. The live c vector changes only after the checksum passes, so a corrupt frame never reaches the routing switches.

Parameters:
- WS, 6, single-track count.
- WD, 3, double-track count.
- WG, 3, global-track count.
- EXTIN, 3, external input pins.
- EXTOUT, 3, external output pins.
- SYNC, 8'hA5, frame sync byte.
- Derived, not overridable:
  - CW = (EXTIN+EXTOUT)*(WS+WD+WG), default 72.
  - CWP = CW rounded up to a multiple of 8, default 72.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_data  input  1  serial configuration bit.
- cfg_ready  output  1  loader accepts a bit this cycle.
- c  output  CW  live configuration vector to the IO block.
- busy  output  1  a frame is in progress (LOAD or CHK).
- done  output  1  one-cycle pulse: frame committed.
- err  output  1  one-cycle pulse: checksum mismatch, frame discarded.

Behaviour:
- Reset values (rst high, asynchronous):
  - c=0, so all gates are off.
  - cfg_ready=0, busy=0, done=0, err=0.
  - state=HUNT, sync window=8'h00, shadow=0, counters=0.
- Transfer rule: a bit is accepted only when cfg_valid && cfg_ready at the rising edge. When cfg_valid is low the loader holds all state, with no timeout.
- Bit order: everything is sent LSB first.
- HUNT:
  - cfg_ready=1.
  - Each accepted bit updates the window: w <= {cfg_data, w[7:1]}.
  - When the updated window equals SYNC, go to LOAD on the same edge. Bits before the sync pattern are ignored.
  - The window is cleared on entry to HUNT.
- LOAD:
  - cfg_ready=1, busy=1.
  - The k-th accepted bit (k=0..CWP-1) is written to shadow[k].
  - Bits k>=CW are pad bits: they are not stored, but they count toward the checksum.
  - A running 8-bit XOR accumulator is updated as acc[k%8] ^= bit.
  - After bit CWP-1, go to CHK.
- CHK:
  - cfg_ready=1, busy=1.
  - Accept 8 checksum bits LSB first into chk.
  - On the edge that accepts the 8th bit, go to COMMIT.
- COMMIT (one cycle):
  - cfg_ready=0, busy=0.
  - If chk==acc: c <= shadow[CW-1:0] and done=1 on the following cycle.
  - Otherwise c is unchanged and err=1 on the following cycle.
  - Go to HUNT.
  - Latency from the last checksum bit accepted to c updating is 2 edges.
- done and err are registered, mutually exclusive, and high for exactly one cycle.
- c holds its value indefinitely and changes only in COMMIT or on reset.
- Reset mid-frame: c returns to 0 immediately (asynchronous) and the partial frame is lost.
- A sync pattern appearing inside payload or checksum bits has no special meaning; it is treated as data.
- Back-to-back frames:
  - The first bit after COMMIT is accepted in HUNT.
  - The sync window starts from zero, so a full 8-bit sync is required for every frame.
- Counters: the LOAD counter is ceil(log2(CWP+1)) bits; the CHK counter is 3 bits. Neither wraps within a frame.

Test Plan:
- Reset, then send the 8 sync bits 1,0,1,0,0,1,0,1, then 72 payload bits with only bit 0 =1, then checksum 8'h01 -> done pulses 2 cycles after the last bit; c==72'h1; err stays 0.
- Send a frame with all 72 payload bits =1 and checksum 8'h01 (nine bytes of FF XOR to FF, so this is wrong) -> err pulses; c keeps its prior value. Resend with checksum 8'hFF -> done pulses; c is all ones.
- Send 5 random garbage bits, then sync, payload 72'h0, checksum 8'h00 -> frame commits; c==0; done pulses once.
- Hold cfg_valid low for random 0–7 cycle gaps between bits of a valid frame -> same final c and done as with gapless input; no bits are lost or duplicated.
- Assert rst for 1 cycle at payload bit 40 of a frame, after a prior committed c=72'h1 -> c goes to 0 immediately, busy=0, no done. A subsequent complete frame commits normally.
- Send two frames back to back with no idle cycles -> cfg_ready is low for exactly one COMMIT cycle between them; both commit and c holds the second payload.
